// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame timing.
// The transmitter also imports this package for BITS.
package uart_pkg;

  localparam int DEFAULT_BITS         = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_e;

endpackage

// File: rtl/data_receive_if.sv
// Serial line plus received-byte handshake between the UART receiver and its consumer.
// The master modport belongs to the consumer side; the slave modport belongs to the receiver.
interface data_receive_if #(
  parameter int BITS = uart_pkg::DEFAULT_BITS
);

  logic            enable;
  logic            bit_in;
  logic            rx_ack;
  logic [BITS-1:0] data_i_bus;
  logic            rx_valid;
  logic            frame_err;
  logic            overrun;

  modport master (
    output enable, bit_in, rx_ack,
    input  data_i_bus, rx_valid, frame_err, overrun
  );

  modport slave (
    input  enable, bit_in, rx_ack,
    output data_i_bus, rx_valid, frame_err, overrun
  );

endinterface

// File: rtl/data_receive_bit_sync.sv
// Two-flop synchroniser for an asynchronous input whose idle level is high.
// The output resets to 1, so no false start edge is seen as reset is released.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/data_receive.sv
// UART 8N1 receiver: bit timing is realigned on every start edge so that each bit
// is sampled mid-cell. Bytes are held behind a valid/ack handshake.
module data_receive
  import uart_pkg::*;
#(
  parameter int BITS         = DEFAULT_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  data_receive_if.slave  rx
);

  localparam logic [12:0] HALF     = 13'((CLKS_PER_BIT - 1) / 2);
  localparam logic [12:0] CPB_LAST = 13'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST = 3'(BITS - 1);

  logic s_in;

  bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx.bit_in),
    .q_o (s_in)
  );

  rx_state_e       state_q,    state_d;
  logic [12:0]     counter_q,  counter_d;
  logic [2:0]      bitIdx_q,   bitIdx_d;
  logic [BITS-1:0] shiftReg_q, shiftReg_d;
  logic [BITS-1:0] data_q,     data_d;
  logic            valid_q,    valid_d;
  logic            ferr_q,     ferr_d;
  logic            overrun_q,  overrun_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    overrun_d  = overrun_q;

    // The ack is applied first so that a byte completing in the same cycle wins.
    if (rx.rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx.enable && !s_in) begin
          state_d   = START;
          counter_d = '0;
        end
      end

      START: begin
        if (counter_q == HALF) begin
          counter_d = '0;
          bitIdx_d  = '0;
          state_d   = s_in ? IDLE : DATA;
        end else begin
          counter_d = counter_q + 13'd1;
        end
      end

      DATA: begin
        if (counter_q == CPB_LAST) begin
          counter_d  = '0;
          shiftReg_d = {s_in, shiftReg_q[BITS-1:1]};
          if (bitIdx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          counter_d = counter_q + 13'd1;
        end
      end

      STOP: begin
        if (counter_q == CPB_LAST) begin
          counter_d = '0;
          if (s_in) begin
            data_d  = shiftReg_q;
            valid_d = 1'b1;
            if (valid_q && !rx.rx_ack) begin
              overrun_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end else begin
          counter_d = counter_q + 13'd1;
        end
      end

      RECOVER: begin
        if (s_in) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx.data_i_bus = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = overrun_q;

endmodule

// File: doc/data_receive.md
Name: data_receive

Overview:
- UART receiver: deserialises an asynchronous 8N1 line into parallel bytes. It is the receive-side counterpart of the existing serial transmitter.
- Bit timing comes from an internal counter that is re-aligned on every start edge. This gives mid-bit sampling, which the transmitter's free-running tick cannot provide.
- Received bytes are held for the consumer behind a valid/ack handshake.
- It sits between the board RX pin and the byte-consuming logic.

Parameters:
- BITS, 8: data bits per frame, sent LSB first.
- CLKS_PER_BIT, 5208: clk cycles per bit (50 MHz / 9600). Legal range 4..8191; the bit counter is 13 bits wide.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  arms reception; sampled only in IDLE.
- bit_in  in  1  raw asynchronous serial line; idles high.
- rx_ack  in  1  one-cycle pulse from the consumer: byte taken.
- data_i_bus  out  8  last good received byte.
- rx_valid  out  1  data_i_bus holds an unacknowledged byte.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  sticky: a byte was overwritten before it was acked.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - Synchroniser flops=1.
  - data_i_bus=0, rx_valid=0, frame_err=0, overrun=0.
- Reset is honoured mid-frame: the partial byte is discarded and the state returns to IDLE.
- bit_in passes through a 2-flop synchroniser (reset value 1). All decisions use its output, s_in, which lags bit_in by 2 cycles.
- Constant HALF = (CLKS_PER_BIT-1)/2, integer division.
- State machine: IDLE, START, DATA, STOP, RECOVER.
  - IDLE:
    - If enable==1 and s_in==0: go to START, counter=0.
    - Otherwise stay.
  - START:
    - counter increments each cycle.
    - When counter==HALF: sample s_in.
    - s_in==0: go to DATA, counter=0, bit index=0.
    - s_in==1: glitch; go to IDLE with no outputs.
  - DATA:
    - When counter==CLKS_PER_BIT-1: sample s_in, shift it into the MSB of the shift register (right shift), counter=0.
    - After BITS samples, go to STOP.
  - STOP: when counter==CLKS_PER_BIT-1, sample s_in.
    - s_in==1: data_i_bus=shift register and rx_valid=1, both on the next edge. Go to IDLE.
    - s_in==0: frame_err=1 for exactly one cycle; data_i_bus and rx_valid unchanged. Go to RECOVER.
  - RECOVER: stay until s_in==1, then go to IDLE. A held-low break yields one frame_err only.
- Once a frame has started, enable is ignored until the frame completes.
- Handshake:
  - rx_valid stays 1 until rx_ack==1, then clears on the next edge.
  - rx_ack while rx_valid==0 is ignored.
- Overwrite rules:
  - Good frame completes while rx_valid==1 and rx_ack==0: data_i_bus is overwritten, overrun=1.
  - Good frame completes in the same cycle as rx_ack: the new byte loads, rx_valid stays 1, overrun is not set.
  - overrun clears only on rx_ack or reset.
- Latency: rx_valid rises one clk after the stop-bit sample, which is about 2 + HALF + (BITS+1)*CLKS_PER_BIT cycles after the falling edge of bit_in.
- Width rules:
  - counter is 13 bits and never wraps: it is cleared at every terminal count.
  - bit index is 3 bits and compared against BITS-1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, STOP, RECOVER), 3 bits;
  - default CLKS_PER_BIT;
  - BITS default.
- The transmitter reuses BITS from the same package.
- One sub-module: bit_sync, a 2-flop synchroniser with reset value 1. It is reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16, enable=1 unless stated):
- Frame 0xA5 (line: 0, then 1,0,1,0,0,1,0,1, then 1) -> data_i_bus=0xA5, rx_valid=1, frame_err=0. Then rx_ack pulse -> rx_valid=0 the next cycle.
- bit_in low for 4 cycles, then high -> FSM returns to IDLE; no rx_valid, no frame_err.
- Frame 0x3C with stop bit 0, line then held low 100 cycles -> exactly one frame_err pulse, rx_valid stays 0, FSM in RECOVER. Line then high and frame 0x55 sent -> data_i_bus=0x55.
- Frames 0x11 then 0x22 with no ack -> data_i_bus=0x22, overrun=1. rx_ack -> rx_valid=0, overrun=0.
- rst=0 asserted mid-DATA of frame 0xFF, then released and frame 0x81 sent -> only 0x81 is received.
- enable=0 and frame 0x77 sent -> no reception.
- enable dropped to 0 during DATA of frame 0x42 -> 0x42 is still delivered.
